// File: rtl/accel_mem_pkg.sv
// Shared types and constants for the banked memory block: controller state,
// default geometry and the legal read-latency range.
package accel_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } mem_state_e;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_ADDR_W   = 16;
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

endpackage

// File: rtl/mem_read_pipe.sv
// Read-return pipeline for one port: READ_LAT stages of valid/data with a flush
// that kills in-flight requests. The last data stage holds when nothing arrives.
module mem_read_pipe
  import accel_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  // Out-of-range latencies are pinned to the nearest legal value.
  localparam int LAT = (READ_LAT < READ_LAT_MIN) ? READ_LAT_MIN :
                       (READ_LAT > READ_LAT_MAX) ? READ_LAT_MAX : READ_LAT;

  logic [LAT-1:0]    valid_q;
  logic [DATA_W-1:0] data_q [LAT];
  logic [LAT-1:0]    valid_in;
  logic [DATA_W-1:0] data_in [LAT];

  always_comb begin
    valid_in[0] = en_i;
    data_in[0]  = data_i;
    for (int i = 1; i < LAT; i++) begin
      valid_in[i] = valid_q[i-1];
      data_in[i]  = data_q[i-1];
    end
  end

  // Data only advances with a live request so rd_data holds between responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < LAT; i++) data_q[i] <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        valid_q[i] <= valid_in[i] & ~flush_i;
        if (valid_in[i] && !flush_i) data_q[i] <= data_in[i];
      end
    end
  end

  assign valid_o = valid_q[LAT-1];
  assign data_o  = data_q[LAT-1];

endmodule

// File: rtl/banked_memory.sv
// Dual-read/dual-write memory with a zero-fill controller (two words per cycle).
// Define BANKED_MEMORY_WRITE_FIRST_EN for write-first reads; default is read-first.
module banked_memory
  import accel_mem_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              busy,
  input  logic              rd_en_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_a,
  output logic              rd_valid_b,
  input  logic              wr_en_a,
  input  logic              wr_en_b,
  input  logic [ADDR_W-1:0] wr_addr_a,
  input  logic [ADDR_W-1:0] wr_addr_b,
  input  logic [DATA_W-1:0] wr_data_a,
  input  logic [DATA_W-1:0] wr_data_b,
  output logic              wr_conflict,
  output mem_state_e        state_o
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = (ADDR_W > 1) ? ADDR_W - 1 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH / 2 - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_conflict_q, wr_conflict_d;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              same_wr_addr;
  logic              we_a, we_b;
  logic              flush;
  logic [ADDR_W-1:0] clr_addr_even, clr_addr_odd;
  logic [DATA_W-1:0] rd_word_a, rd_word_b;

  assign ready        = (state_q == ST_READY);
  assign same_wr_addr = (wr_addr_a == wr_addr_b);
  assign we_a         = ready & wr_en_a;
  // Port B loses an address collision with port A.
  assign we_b         = ready & wr_en_b & ~(wr_en_a & same_wr_addr);
  assign flush        = clear_req | ~ready;

  assign clr_addr_even = ADDR_W'({cnt_q, 1'b0});
  assign clr_addr_odd  = clr_addr_even | ADDR_W'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_conflict_d = we_a & wr_en_b & same_wr_addr;
    unique case (state_q)
      ST_CLEAR: begin
        if (clear_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_CLEAR;
      cnt_q         <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  // Array is never reset; the fill that follows reset establishes its contents.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_addr_even] <= '0;
      mem[clr_addr_odd]  <= '0;
    end else begin
      if (we_b) mem[wr_addr_b] <= wr_data_b;
      if (we_a) mem[wr_addr_a] <= wr_data_a;
    end
  end

`ifdef BANKED_MEMORY_WRITE_FIRST_EN
  always_comb begin
    rd_word_a = mem[rd_addr_a];
    rd_word_b = mem[rd_addr_b];
    if (we_b && (wr_addr_b == rd_addr_a)) rd_word_a = wr_data_b;
    if (we_a && (wr_addr_a == rd_addr_a)) rd_word_a = wr_data_a;
    if (we_b && (wr_addr_b == rd_addr_b)) rd_word_b = wr_data_b;
    if (we_a && (wr_addr_a == rd_addr_b)) rd_word_b = wr_data_a;
  end
`else
  assign rd_word_a = mem[rd_addr_a];
  assign rd_word_b = mem[rd_addr_b];
`endif

  mem_read_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .en_i    (ready & rd_en_a),
    .data_i  (rd_word_a),
    .valid_o (rd_valid_a),
    .data_o  (rd_data_a)
  );

  mem_read_pipe #(.DATA_W(DATA_W), .READ_LAT(READ_LAT)) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .en_i    (ready & rd_en_b),
    .data_i  (rd_word_b),
    .valid_o (rd_valid_b),
    .data_o  (rd_data_b)
  );

  assign busy        = ~ready;
  assign wr_conflict = wr_conflict_q;
  assign state_o     = state_q;

endmodule

// File: doc/banked_memory.md
BANKED_MEMORY -- requirements
Module: banked_memory

Interface
REQ-001 Parameter DATA_W, default 18, data word width in bits.
REQ-002 Parameter ADDR_W, default 16, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter READ_LAT, default 1, legal range 1..3, read latency in cycles from rd_en_x to rd_valid_x.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 clear_req  input  1  pulse; requests a full zero-fill of the memory.
REQ-007 busy  output  1  high while zero-fill is in progress.
REQ-008 rd_en_a, rd_en_b  input  1  read request, ports A/B.
REQ-009 rd_addr_a, rd_addr_b  input  ADDR_W  read address, ports A/B.
REQ-010 rd_data_a, rd_data_b  output  DATA_W  read data, ports A/B.
REQ-011 rd_valid_a, rd_valid_b  output  1  rd_data_x holds valid data this cycle.
REQ-012 wr_en_a, wr_en_b  input  1  write enable, ports A/B.
REQ-013 wr_addr_a, wr_addr_b  input  ADDR_W  write address, ports A/B.
REQ-014 wr_data_a, wr_data_b  input  DATA_W  write data, ports A/B.
REQ-015 wr_conflict  output  1  one-cycle pulse: both write ports hit the same address in the same cycle.

Function
REQ-016 FSM states CLEAR and READY; CLEAR -> READY when the clear counter has covered all DEPTH words; READY -> CLEAR on clear_req.
REQ-017 In CLEAR: both internal write ports write zero (even/odd address pair per cycle); the fill takes DEPTH/2 cycles; busy = 1.
REQ-018 In CLEAR: user writes are dropped, rd_en_x is ignored, and no rd_valid_x is issued.
REQ-019 clear_req while in CLEAR restarts the counter at 0.
REQ-020 In READY: rd_en_x at cycle t produces rd_valid_x = 1 and rd_data_x = mem[rd_addr_x] at cycle t+READ_LAT; rd_valid_x is 0 otherwise.
REQ-021 rd_data_x holds its last value while rd_valid_x = 0.
REQ-022 Read requests already in the pipeline when CLEAR is entered are discarded; their rd_valid_x stays 0.
REQ-023 Writes in READY commit on the clock edge where wr_en_x = 1.
REQ-024 wr_en_a and wr_en_b high with equal addresses: port A data is stored, port B is dropped, and wr_conflict = 1 in the following cycle.
REQ-025 Read and write to the same address in the same cycle follow the rule set in Configuration.
REQ-026 Address arithmetic is unsigned, ADDR_W bits wide; there is no out-of-range case.

Reset
REQ-027 rst = 1 forces: state = CLEAR, clear counter = 0, busy = 1, rd_valid_a/b = 0, rd_data_a/b = 0, wr_conflict = 0, read pipeline flushed.
REQ-028 Array contents are not reset directly; the zero-fill that follows reset deassertion establishes them.
REQ-029 rst asserted mid-fill or mid-read aborts the operation; the fill restarts from address 0 after deassertion.

Configuration
REQ-030 Macro BANKED_MEMORY_WRITE_FIRST_EN defined: a same-cycle read and write to one address returns the new write data (bypass path; port A data wins if both writes hit that address).
REQ-031 Macro undefined: a same-cycle read and write to one address returns the old stored data (read-first), matching block-RAM read-first mode.

Structure
REQ-032 Package accel_mem_pkg holds the FSM state enum, default DATA_W/ADDR_W constants and the READ_LAT bounds.
REQ-033 Sub-module mem_read_pipe (one instance per read port) holds the READ_LAT-deep valid/data shift pipeline with a flush input.

Verification (ADDR_W=4, DATA_W=18, READ_LAT=2 unless noted)
REQ-034 Release rst -> busy = 1 for exactly 8 cycles, then 0; a read of each of the 16 addresses returns 0.
REQ-035 In READY, write 0x2A5 to address 3, then read address 3 -> rd_valid_a = 1 exactly 2 cycles after rd_en_a, rd_data_a = 0x2A5.
REQ-036 wr_a(5, 0x111) and wr_b(5, 0x222) in the same cycle -> wr_conflict pulses for 1 cycle; a later read of address 5 = 0x111.
REQ-037 Address 7 holds 0x010; write 0x0FF and read address 7 in the same cycle -> read returns 0x0FF with the macro defined, 0x010 without.
REQ-038 Issue a read, then assert clear_req on the next cycle -> no rd_valid pulse; after busy falls, address 3 reads 0.
REQ-039 Assert rst at the 4th cycle of the fill, then release -> busy = 1 for 8 full cycles again; reads behave normally afterwards.
